// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for uart_tx (optional UART_TX_PARITY_EN adds the PARITY state)
package uart_pkg;

  // Width of the bit-period counter; bounds the largest usable divider.
  localparam int TICK_W = 16;

  // Frame states. Encodings are fixed so they can be mirrored as plain
  // localparam constants inside the FSM.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } uart_state_e;

  // Clock cycles per bit, rounded to nearest: (CLOCK*1e6 + BAUD/2) / BAUD.
  // Done in 64-bit so large clock frequencies do not overflow.
  function automatic int calc_div(input int clock_mhz, input int baud);
    longint num;
    num = longint'(clock_mhz) * longint'(1000000) + longint'(baud / 2);
    return int'(num / longint'(baud));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter producing a one-cycle tick every DIV cycles
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(DIV - 1);

  logic [TICK_W-1:0] count;

  // The tick marks the last cycle of a bit period; a restart in the same
  // cycle takes priority so a new frame always begins with a full period.
  assign tick = run && !restart && (count == LAST);

  // Counter is held at zero when not running so it never free-runs while idle,
  // and self-clears on the tick so every bit period starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || !run || tick) begin
      count <= '0;
    end else begin
      count <= count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit (8E1)
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK = 50,
  parameter int BAUD  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int DIV = calc_div(CLOCK, BAUD);

  // Divider must give at least two cycles per bit and fit the tick counter.
  if (DIV < 2 || DIV > 65535) begin : g_div_check
    $error("uart_tx: bit period DIV out of range 2..65535");
  end

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_STOP   = ST_STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = ST_PARITY;
`endif

  logic [2:0] state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       accept;
  logic       tick;
`ifdef UART_TX_PARITY_EN
  logic       par_bit;
`endif

  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = tx_valid && tx_ready;

  // Acceptance restarts the bit timer; every later state change happens on
  // a tick, which clears the counter by itself.
  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (busy),
    .restart(accept),
    .tick   (tick)
  );

`ifdef UART_TX_PARITY_EN
  // Even parity is taken from the byte as accepted, since the shift register
  // is consumed while the data bits go out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ^tx_data;
    end
  end
`endif

  // Frame sequencer: txd is registered and always updated together with the
  // state, so each bit level lasts exactly one full bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shift   <= 8'h00;
      bit_idx <= 3'd0;
      txd     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (accept) begin
            shift   <= tx_data;
            bit_idx <= 3'd0;
            state   <= S_START;
            txd     <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            state <= S_DATA;
            txd   <= shift[0];
            shift <= {1'b0, shift[7:1]};
          end
        end
        S_DATA: begin
          if (tick) begin
            // Index wraps 7 -> 0 naturally on the last data bit.
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              txd   <= par_bit;
`else
              state <= S_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd   <= shift[0];
              shift <= {1'b0, shift[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            state <= S_STOP;
            txd   <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            state <= S_IDLE;
            txd   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;

  localparam int CLOCK = 50;
  localparam int BAUD  = 115200;
  localparam int DIV   = (CLOCK * 1000000 + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NB    = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  uart_tx #(
    .CLOCK(CLOCK),
    .BAUD (BAUD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd     (txd),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Line level of bit slot n of a frame carrying byte b.
  function automatic logic line_bit(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (PAR && n == 9) return ^b;
    return 1'b1;
  endfunction

  // Reference model: m_k is the cycle number within the current frame
  // (-1 when idle). A frame starts the cycle after an idle cycle sees tx_valid.
  int         m_k;
  logic [7:0] m_byte;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k    <= -1;
      m_byte <= 8'h00;
    end else if (m_k < 0) begin
      if (tx_valid) begin
        m_byte <= tx_data;
        m_k    <= 0;
      end
    end else if (m_k == FRAME - 1) begin
      m_k <= -1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Every cycle: {txd, tx_ready, busy} against the model.
  always @(negedge clk) begin
    logic [2:0] exp;
    if (chk_en) begin
      if (m_k < 0) exp = 3'b110;
      else         exp = {line_bit(m_byte, m_k / DIV), 1'b0, 1'b1};
      check("line", 32'({txd, tx_ready, busy}), 32'(exp));
    end
  end

  // Called on a negedge while idle: offers one byte for one cycle and
  // measures cycles from START entry until tx_ready returns.
  task automatic send_measure(input logic [7:0] b, input string tag);
    int n;
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    n = 0;
    while (!tx_ready && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n), 32'(FRAME));
  endtask

  initial begin
    int wait_n;
    logic [7:0] b;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    send_measure(8'h55, "len_55");
    repeat (2) @(negedge clk);
    send_measure(8'h01, "len_01");
    repeat (2) @(negedge clk);

    // tx_valid held across two frames; data changes during the first frame.
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h0F;
    repeat (FRAME) @(negedge clk);
    check("b2b_gap_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    check("b2b_second_busy", 32'(busy), 32'd1);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    repeat (FRAME + 3) @(negedge clk);

    // A tx_valid pulse with different data while busy must be ignored.
    b        = 8'($urandom);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat ($urandom_range(10, FRAME - 10)) @(negedge clk);
    tx_data  = ~b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_n = 0;
    while (!tx_ready && wait_n < 2 * FRAME) begin
      @(negedge clk);
      wait_n++;
    end
    check("pulse_done", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Random bytes with random idle gaps.
    for (int i = 0; i < 5; i++) begin
      send_measure(8'($urandom), "len_rand");
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // Reset in the middle of data bit 3 abandons the frame.
    tx_data  = 8'hC6;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4 * DIV + DIV / 2 - 1) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ready", 32'(tx_ready), 32'd1);
    repeat (2 * DIV) @(negedge clk);
    check("midrst_idle_txd", 32'(txd), 32'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLOCK, default 50, SHALL be the system clock frequency in MHz.
REQ-002 Parameter BAUD, default 115200, SHALL be the line rate in bit/s.
REQ-003 clk  input  1  SHALL be the single clock; all logic rising-edge triggered.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 tx_data  input  8  SHALL be the byte to send; sampled only on acceptance.
REQ-006 tx_valid  input  1  SHALL indicate tx_data is valid.
REQ-007 tx_ready  output  1  SHALL indicate the block can accept a byte this cycle.
REQ-008 txd  output  1  SHALL be the serial line; idle high.
REQ-009 busy  output  1  SHALL be high whenever a frame is in progress (state not IDLE).

Function
REQ-010 Bit period DIV SHALL be (CLOCK*1000000 + BAUD/2)/BAUD cycles (434 at defaults); DIV < 2 or DIV > 65535 SHALL be an elaboration error.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 tx_ready SHALL be 1 only in IDLE; acceptance SHALL be tx_valid && tx_ready on a clock edge.
REQ-013 On acceptance, tx_data SHALL be latched into a shift register and the FSM SHALL enter START the next cycle with txd=0.
REQ-014 tx_valid without tx_ready SHALL be ignored; tx_data changes mid-frame SHALL NOT affect the frame.
REQ-015 Each of START, every data bit, PARITY and STOP SHALL hold txd for exactly DIV cycles.
REQ-016 DATA SHALL send 8 bits LSB first, using a 3-bit index that wraps 7->0 on leaving DATA.
REQ-017 STOP SHALL drive txd=1 for DIV cycles, then return to IDLE; tx_ready SHALL rise the cycle after STOP ends.
REQ-018 With tx_valid held high, frames SHALL be back-to-back with exactly one IDLE cycle between STOP end and the next START.
REQ-019 Bit-period counter SHALL reload to 0 on every state change and on acceptance; it SHALL NOT free-run in IDLE.
REQ-020 txd SHALL be registered (glitch-free).

Reset
REQ-021 On rst_n low, regardless of state or mid-frame position: state=IDLE, txd=1, tx_ready=1 after release, busy=0, counter=0, bit index=0, shift register=0.
REQ-022 A frame interrupted by reset SHALL be abandoned, not resumed.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: PARITY state SHALL be inserted after DATA, sending even parity (XOR of the 8 data bits); frame = 11*DIV cycles.
REQ-024 Macro undefined: no PARITY state or logic SHALL exist; frame = 10*DIV cycles.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum typedef and a constant function computing DIV from CLOCK and BAUD.
REQ-026 Sub-module uart_baud_tick (counter, DIV-cycle terminal tick, synchronous restart input) SHALL produce the bit-period tick.

Verification
REQ-027 Reset mid-frame (during DATA bit 3) -> txd=1, busy=0 immediately; tx_ready=1 after release; no further bit edges.
REQ-028 Send 0x55, defaults, no parity -> txd = 0,1,0,1,0,1,0,1,0,1, each held 434 cycles; tx_ready rises 4340 cycles after START entry.
REQ-029 tx_valid held, bytes 0xA3 then 0x0F -> second start bit begins exactly 1 cycle after first stop ends; both bytes decode correctly.
REQ-030 tx_valid pulsed while busy, tx_data changed mid-frame -> pulse ignored; transmitted byte equals the originally accepted value.
REQ-031 UART_TX_PARITY_EN, send 0x01 -> parity bit 1; send 0x55 -> parity bit 0; frame 4774 cycles.
REQ-032 CLOCK=1, BAUD=1000000 (DIV=1) -> elaboration fails.
